ap_vector_mem: RTL and testbench

Parametrised vector memory for the AP datapath: one synchronous write port with per-element write mask, one random-access registered read port, and a burst read engine that streams consecutive rows over a valid/ready handshake. It replaces the fixed 8×32-bit, 2001-row, combinational-read row store. Rows are sized to a full vector of processing units.

---
 rtl/ap_vector_mem.sv | 228 ++++++++++++++++++++++
 tb/tb_ap_vector_mem.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_vector_mem.sv
// Row-organised vector memory: masked synchronous write, registered random read,
// and a burst engine that streams consecutive rows over a valid/ready handshake.
module ap_vector_mem #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int DEPTH         = 2048,
  parameter int ADDR_WIDTH    = 11
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  // write port
  input  logic                                   wr_en,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  input  logic [NO_OF_UNITS-1:0]                 wr_mask,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   wr_data,
  // random read port
  input  logic                                   rd_en,
  input  logic [ADDR_WIDTH-1:0]                  rd_addr,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   rd_data,
  output logic                                   rd_valid,
  // burst read engine
  input  logic                                   bst_start,
  input  logic [ADDR_WIDTH-1:0]                  bst_base,
  input  logic [ADDR_WIDTH:0]                    bst_len,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   bst_data,
  output logic                                   bst_valid,
  input  logic                                   bst_ready,
  output logic                                   bst_last,
  output logic                                   bst_busy,
  output logic                                   bst_done,
  output logic                                   addr_err
);

  localparam int W     = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_LEFT  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH_EXT;
  endfunction

  logic [W-1:0] mem [DEPTH];

  logic             wr_ok;
  logic             rd_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_ok  = wr_en & in_range(wr_addr);
  assign rd_ok  = in_range(rd_addr);
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
  // nothing may rely on its contents before they have been written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < NO_OF_UNITS; i++) begin
        if (wr_mask[i]) begin
          mem[wr_idx][i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= wr_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Random read port
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking updates mean this read samples the array as it was before
  // the edge, so a same-cycle write to the same row is seen as old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_ok ? mem[rd_idx] : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst engine
  // ---------------------------------------------------------------------------
  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [ADDR_WIDTH:0]   issue_left;   // rows still to be read from the array

  // one registered array read in flight between issue and the output buffer
  logic                  infl_valid;
  logic [W-1:0]          infl_data;
  logic                  infl_last;

  // second buffer slot; the first slot is the bst_* output register itself
  logic                  spare_valid;
  logic [W-1:0]          spare_data;
  logic                  spare_last;

  logic                  pop;
  logic [1:0]            pending;
  logic                  issue;
  logic                  bad_base;

  assign pop      = bst_valid & bst_ready;
  assign ptr_next = (ptr == LAST_ROW) ? '0 : ptr + 1'b1;
  assign bad_base = (state == S_IDLE) & bst_start & ~in_range(bst_base);

  // Beats leaving this cycle free their slot immediately, which keeps the
  // stream back-to-back when the consumer never stalls.
  assign pending = 2'(bst_valid) + 2'(spare_valid) + 2'(infl_valid) - 2'(pop);
  assign issue   = (state == S_RUN) && (issue_left != '0) && (pending < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      issue_left  <= '0;
      infl_valid  <= 1'b0;
      infl_data   <= '0;
      infl_last   <= 1'b0;
      spare_valid <= 1'b0;
      spare_data  <= '0;
      spare_last  <= 1'b0;
      bst_valid   <= 1'b0;
      bst_data    <= '0;
      bst_last    <= 1'b0;
      bst_busy    <= 1'b0;
      bst_done    <= 1'b0;
    end else begin
      infl_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bst_start) begin
            bst_busy <= 1'b1;
            if (!in_range(bst_base) || bst_len == '0) begin
              state    <= S_DONE;
              bst_done <= 1'b1;
            end else begin
              state      <= S_RUN;
              ptr        <= bst_base;
              issue_left <= bst_len;
            end
          end
        end

        S_RUN: begin
          if (issue) begin
            infl_valid <= 1'b1;
            infl_data  <= mem[ptr[IDX_W-1:0]];
            infl_last  <= (issue_left == ONE_LEFT);
            ptr        <= ptr_next;
            issue_left <= issue_left - 1'b1;
          end
          if (pop && bst_last) begin
            state    <= S_DONE;
            bst_done <= 1'b1;
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          bst_done <= 1'b0;
          bst_busy <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          bst_done <= 1'b0;
          bst_busy <= 1'b0;
        end
      endcase

      // Two-slot buffer: the head advances when empty or accepted, refilling
      // from the spare slot first so beat order is preserved.
      if (pop || !bst_valid) begin
        if (spare_valid) begin
          bst_valid <= 1'b1;
          bst_data  <= spare_data;
          bst_last  <= spare_last;
          if (infl_valid) begin
            spare_data <= infl_data;
            spare_last <= infl_last;
          end else begin
            spare_valid <= 1'b0;
          end
        end else if (infl_valid) begin
          bst_valid <= 1'b1;
          bst_data  <= infl_data;
          bst_last  <= infl_last;
        end else begin
          bst_valid <= 1'b0;
          bst_last  <= 1'b0;
        end
      end else if (infl_valid) begin
        spare_valid <= 1'b1;
        spare_data  <= infl_data;
        spare_last  <= infl_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Address error flag: one pulse for any out-of-range access in the last cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (wr_en & ~in_range(wr_addr)) | (rd_en & ~rd_ok) | bad_base;
    end
  end

endmodule

// File: tb/tb_ap_vector_mem.sv
// Self-checking bench for ap_vector_mem: a row-array/beat-queue model checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_ap_vector_mem;

  localparam int EW    = 32;
  localparam int NU    = 8;
  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int W     = EW * NU;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NU-1:0] wr_mask;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          bst_start;
  logic [AW-1:0] bst_base;
  logic [AW:0]   bst_len;
  logic [W-1:0]  bst_data;
  logic          bst_valid;
  logic          bst_ready;
  logic          bst_last;
  logic          bst_busy;
  logic          bst_done;
  logic          addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  ap_vector_mem #(
    .ELEMENT_WIDTH(EW),
    .NO_OF_UNITS  (NU),
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .bst_start(bst_start),
    .bst_base (bst_base),
    .bst_len  (bst_len),
    .bst_data (bst_data),
    .bst_valid(bst_valid),
    .bst_ready(bst_ready),
    .bst_last (bst_last),
    .bst_busy (bst_busy),
    .bst_done (bst_done),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Row r, element i holds (r << 8) | i after preload.
  function automatic logic [W-1:0] pat(input int r);
    logic [W-1:0] v;
    for (int i = 0; i < NU; i++) v[i*EW +: EW] = EW'((r << 8) | i);
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: plain row array, queue of beats still owed to the consumer
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem_m [DEPTH];
  logic [W-1:0] beat_q [$];
  logic [W-1:0] exp_rd_data  = '0;
  logic         exp_rd_valid = 1'b0;
  logic         exp_busy     = 1'b0;
  logic         exp_done     = 1'b0;
  logic         exp_err      = 1'b0;

  always @(posedge clk) begin
    logic hs;
    hs = bst_valid && bst_ready;
    if (!rst_n) begin
      beat_q.delete();
      exp_rd_data  = '0;
      exp_rd_valid = 1'b0;
      exp_busy     = 1'b0;
      exp_done     = 1'b0;
      exp_err      = 1'b0;
    end else begin
      exp_err = (wr_en && int'(wr_addr) >= DEPTH) || (rd_en && int'(rd_addr) >= DEPTH) ||
                (!exp_busy && bst_start && int'(bst_base) >= DEPTH);
      if (rd_en) begin
        exp_rd_valid = 1'b1;
        exp_rd_data  = (int'(rd_addr) < DEPTH) ? mem_m[int'(rd_addr)] : '0;
      end else begin
        exp_rd_valid = 1'b0;
      end
      if (exp_done) begin
        exp_done = 1'b0;
        exp_busy = 1'b0;
      end else if (!exp_busy && bst_start) begin
        exp_busy = 1'b1;
        if (int'(bst_base) >= DEPTH || bst_len == '0) exp_done = 1'b1;
        else for (int k = 0; k < int'(bst_len); k++) beat_q.push_back(mem_m[(int'(bst_base) + k) % DEPTH]);
      end else if (exp_busy && hs && beat_q.size() > 0) begin
        void'(beat_q.pop_front());
        if (beat_q.size() == 0) exp_done = 1'b1;
      end
      if (wr_en && int'(wr_addr) < DEPTH) begin
        for (int i = 0; i < NU; i++)
          if (wr_mask[i]) mem_m[int'(wr_addr)][i*EW +: EW] = wr_data[i*EW +: EW];
      end
    end
    #1;
    check("rd_valid", rd_valid, exp_rd_valid);
    check("rd_data", rd_data, exp_rd_data);
    check("addr_err", addr_err, exp_err);
    check("bst_busy", bst_busy, exp_busy);
    check("bst_done", bst_done, exp_done);
    check("bst_valid_without_owed_beat", bst_valid && beat_q.size() == 0, 1'b0);
    if (bst_valid && beat_q.size() > 0) begin
      check("bst_data", bst_data, beat_q[0]);
      check("bst_last", bst_last, beat_q.size() == 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic run_burst(input int base, input int len, input int budget,
                           input bit with_rd, output int beats);
    bit seen;
    seen  = 1'b0;
    beats = 0;
    bst_base  = AW'(base);
    bst_len   = (AW+1)'(len);
    bst_start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bst_start = 1'b0;
      if (with_rd) begin
        rd_en   = 1'b1;
        rd_addr = AW'((c * 7) % DEPTH);
      end
      if (bst_done) begin
        seen = 1'b1;
        break;
      end
      if (bst_valid && bst_ready) beats++;
    end
    rd_en = 1'b0;
    check("burst_done_within_budget", seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] row_a;
    logic [W-1:0] row_b;
    logic [EW-1:0] got_q [$];
    bit  rp [4];
    bit  seen;
    int  beats;

    rst_n     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_mask   = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    bst_start = 1'b0;
    bst_base  = '0;
    bst_len   = '0;
    bst_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check("reset_rd_data", rd_data, '0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_bst_data", bst_data, '0);
    check("reset_bst_valid", bst_valid, 1'b0);
    check("reset_bst_last", bst_last, 1'b0);
    check("reset_bst_busy", bst_busy, 1'b0);
    check("reset_bst_done", bst_done, 1'b0);
    check("reset_addr_err", addr_err, 1'b0);
    rst_n = 1'b1;

    // preload every row so the array is fully known
    for (int r = 0; r < DEPTH; r++) begin
      wr_en = 1'b1; wr_addr = AW'(r); wr_mask = '1; wr_data = pat(r);
      @(negedge clk);
    end
    wr_en = 1'b0;

    // masked write
    wr_en = 1'b1; wr_addr = 8'd5; wr_mask = 8'hFF;
    wr_data = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    @(negedge clk);
    wr_mask = 8'h01; wr_data = {8{32'hFFFFFFFF}};
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd5;
    @(negedge clk);
    rd_en = 1'b0;
    check("masked_rd_valid", rd_valid, 1'b1);
    check("masked_rd_data", rd_data,
          256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_FFFFFFFF);
    @(negedge clk);
    check("masked_rd_valid_pulse", rd_valid, 1'b0);

    // read-during-write returns old contents
    row_a = {8{32'hAAAA0009}};
    row_b = {8{32'hBBBB0009}};
    wr_en = 1'b1; wr_addr = 8'd9; wr_mask = '1; wr_data = row_a;
    @(negedge clk);
    wr_data = row_b; rd_en = 1'b1; rd_addr = 8'd9;
    @(negedge clk);
    wr_en = 1'b0;
    check("rdw_old_data", rd_data, row_a);
    @(negedge clk);
    rd_en = 1'b0;
    check("rdw_new_data", rd_data, row_b);

    // full-rate burst of rows 100..103
    bst_ready = 1'b1;
    bst_start = 1'b1; bst_base = 8'd100; bst_len = 9'd4;
    @(negedge clk);
    bst_start = 1'b0;
    check("fr_busy_after_start", bst_busy, 1'b1);
    check("fr_no_valid_t1", bst_valid, 1'b0);
    @(negedge clk);
    check("fr_no_valid_t2", bst_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fr_valid", bst_valid, 1'b1);
      check("fr_elem0", bst_data[EW-1:0], 32'h6400 + 32'(k * 256));
      check("fr_last", bst_last, k == 3);
    end
    @(negedge clk);
    check("fr_done", bst_done, 1'b1);
    check("fr_valid_after", bst_valid, 1'b0);
    @(negedge clk);
    check("fr_done_pulse", bst_done, 1'b0);
    check("fr_idle", bst_busy, 1'b0);

    // backpressure with address wrap
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    seen = 1'b0;
    bst_start = 1'b1; bst_base = 8'(DEPTH - 2); bst_len = 9'd4;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bst_start = 1'b0;
      if (bst_done) begin
        seen = 1'b1;
        break;
      end
      bst_ready = rp[c % 4];
      if (bst_valid && bst_ready) got_q.push_back(bst_data[EW-1:0]);
    end
    bst_ready = 1'b1;
    check("bp_done_seen", seen, 1'b1);
    check("bp_beat_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("bp_beat0", got_q[0], 32'hC600);
      check("bp_beat1", got_q[1], 32'hC700);
      check("bp_beat2", got_q[2], 32'h0000);
      check("bp_beat3", got_q[3], 32'h0100);
    end
    @(negedge clk);

    // zero-length burst
    bst_start = 1'b1; bst_base = 8'd3; bst_len = 9'd0;
    @(negedge clk);
    bst_start = 1'b0;
    check("len0_done", bst_done, 1'b1);
    check("len0_no_valid", bst_valid, 1'b0);
    @(negedge clk);
    check("len0_done_pulse", bst_done, 1'b0);
    check("len0_idle", bst_busy, 1'b0);

    // out-of-range burst base
    bst_start = 1'b1; bst_base = 8'(DEPTH); bst_len = 9'd3;
    @(negedge clk);
    bst_start = 1'b0;
    check("badbase_err", addr_err, 1'b1);
    check("badbase_done", bst_done, 1'b1);
    @(negedge clk);
    check("badbase_err_pulse", addr_err, 1'b0);
    check("badbase_no_valid", bst_valid, 1'b0);

    // out-of-range write is dropped
    wr_en = 1'b1; wr_addr = 8'(DEPTH); wr_mask = '1; wr_data = '1;
    @(negedge clk);
    wr_en = 1'b0;
    check("badwr_err", addr_err, 1'b1);

    // out-of-range read returns zeros
    rd_en = 1'b1; rd_addr = 8'(DEPTH);
    @(negedge clk);
    rd_en = 1'b0;
    check("badrd_data", rd_data, '0);
    check("badrd_valid", rd_valid, 1'b1);
    check("badrd_err", addr_err, 1'b1);

    // reset during beat 2 of an 8-row burst
    rd_en = 1'b1; rd_addr = 8'd5;
    bst_start = 1'b1; bst_base = 8'd50; bst_len = 9'd8;
    @(negedge clk);
    bst_start = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_beat2", bst_data[EW-1:0], 32'h3300);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rd_data", rd_data, '0);
    check("rst_mid_bst_data", bst_data, '0);
    check("rst_mid_bst_valid", bst_valid, 1'b0);
    check("rst_mid_bst_last", bst_last, 1'b0);
    check("rst_mid_bst_busy", bst_busy, 1'b0);
    check("rst_mid_bst_done", bst_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // new burst after release, then a whole-array sweep with concurrent reads
    run_burst(60, 3, 20, 1'b0, beats);
    check("post_rst_beats", beats, 3);
    @(negedge clk);
    run_burst(0, DEPTH, DEPTH + 20, 1'b1, beats);
    check("sweep_beats", beats, DEPTH);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
